// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the instruction-fetch front end:
//               fetch FSM state encoding, reset PC default, opcode field
//               bounds and the NOP instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } if_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Primary opcode field of a MIPS instruction word.
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;

  // sll $0,$0,0 -- the canonical MIPS no-op.
  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Combinational next-PC selection for the fetch stage.
//               Priority: jump > branch > pending (squashed) target >
//               sequential increment.
// Ports       : pc, pc_out            - current fetch PC / held-instr PC
//               jump, jump_index      - jump redirect and 26-bit index
//               branch_taken,
//               branch_target         - branch redirect and byte target
//               use_pend, pend_pc     - deferred redirect captured earlier
//               redirect              - jump OR branch_taken this cycle
//               redirect_pc           - target of this cycle's redirect
//               next_pc               - selected next fetch PC
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel #(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_out,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        use_pend,
  input  logic [31:0] pend_pc,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] next_pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [3:0]  jump_region;
  logic [31:0] jump_pc;
  logic [31:0] branch_pc;
  logic [31:0] seq_pc;

  // Jump stays inside the 256 MB region of the instruction after the held one.
  assign jump_region = 4'((pc_out + 32'd4) >> 28);
  assign jump_pc     = {jump_region, jump_index, 2'b00};
  // Force word alignment of the branch target.
  assign branch_pc   = branch_target & ~32'h0000_0003;
  // Modulo-2^32 wrap comes for free from the 32-bit adder.
  assign seq_pc      = pc + STEP;

  assign redirect    = jump | branch_taken;
  assign redirect_pc = jump ? jump_pc : branch_pc;

  always_comb begin
    next_pc = seq_pc;
    if (redirect) begin
      next_pc = redirect_pc;
    end else if (use_pend) begin
      next_pc = pend_pc;
    end
  end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Issues one read at a time to the
//               instruction memory, holds the returned word until decode
//               accepts it, and handles jump/branch redirects, including
//               ones that arrive while a read is still outstanding.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               imem_req, imem_addr   - read request / word address
//               imem_ack, imem_rdata  - one-cycle response and data
//               jump, jump_index      - jump redirect
//               branch_taken,
//               branch_target         - branch redirect
//               out_ready             - decode accepts the held instruction
//               out_valid, instr,
//               opcode, pc_out        - held instruction to decode
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out
);

  if_state_t   state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_out_next;
  logic [31:0] instr_next;
  logic        out_valid_next;
  logic        squash, squash_next;
  logic [31:0] pend_pc, pend_pc_next;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  next_pc_sel #(
    .PC_STEP (PC_STEP)
  ) u_next_pc_sel (
    .pc            (pc),
    .pc_out        (pc_out),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .use_pend      (squash),
    .pend_pc       (pend_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      pc_out    <= RESET_PC;
      instr     <= NOP;
      out_valid <= 1'b0;
      squash    <= 1'b0;
      pend_pc   <= 32'h0000_0000;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      pc_out    <= pc_out_next;
      instr     <= instr_next;
      out_valid <= out_valid_next;
      squash    <= squash_next;
      pend_pc   <= pend_pc_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    pc_out_next    = pc_out;
    instr_next     = instr;
    out_valid_next = out_valid;
    squash_next    = squash;
    pend_pc_next   = pend_pc;

    unique case (state)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        if (imem_ack) begin
          // next_pc already folds in redirect > pending > sequential.
          pc_next     = next_pc;
          squash_next = 1'b0;
          if (!redirect && !squash) begin
            instr_next     = imem_rdata;
            pc_out_next    = pc;
            out_valid_next = 1'b1;
            state_next     = HOLD;
          end
        end else if (redirect) begin
          // The read in flight cannot be cancelled on the bus, so keep the
          // address stable and drop its data when it finally returns.
          squash_next  = 1'b1;
          pend_pc_next = redirect_pc;
        end
      end

      HOLD: begin
        if (redirect) begin
          out_valid_next = 1'b0;
          pc_next        = redirect_pc;
          state_next     = FETCH;
        end else if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign opcode    = instr[OPCODE_HI:OPCODE_LO];

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage. Inputs change 1 ns
//               after each rising edge; outputs are checked at that point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .instr         (instr),
    .opcode        (opcode),
    .pc_out        (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    jump = 1'b0; jump_index = 26'h0;
    branch_taken = 1'b0; branch_target = 32'h0; out_ready = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_req",   {31'h0, imem_req},  32'h0);
    chk("rst_pcout", pc_out, 32'h0);
    chk("rst_instr", instr,  32'h0);
    chk("rst_addr",  imem_addr, 32'h0);

    // Release: IDLE one cycle, then FETCH at RESET_PC
    reset = 1'b0;
    step();
    chk("f0_req",  {31'h0, imem_req}, 32'h1);
    chk("f0_addr", imem_addr, 32'h0);

    // lw fetched
    imem_ack = 1'b1; imem_rdata = 32'h8C01_0004;
    step();
    imem_ack = 1'b0;
    chk("lw_valid",  {31'h0, out_valid}, 32'h1);
    chk("lw_opcode", {26'h0, opcode}, 32'h23);
    chk("lw_instr",  instr, 32'h8C01_0004);
    chk("lw_pcout",  pc_out, 32'h0);
    chk("lw_addr",   imem_addr, 32'h4);
    chk("lw_req",    {31'h0, imem_req}, 32'h0);

    // Stall 5 cycles in HOLD; a stray ack here must be ignored
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      imem_ack = 1'b0;
      chk("hold_valid", {31'h0, out_valid}, 32'h1);
      chk("hold_instr", instr, 32'h8C01_0004);
      chk("hold_pcout", pc_out, 32'h0);
      chk("hold_req",   {31'h0, imem_req}, 32'h0);
    end

    // Accept -> FETCH at 4
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("acc_valid", {31'h0, out_valid}, 32'h0);
    chk("acc_req",   {31'h0, imem_req}, 32'h1);
    chk("acc_addr",  imem_addr, 32'h4);

    imem_ack = 1'b1; imem_rdata = 32'h2002_0005;
    step();
    imem_ack = 1'b0;
    chk("i1_pcout", pc_out, 32'h4);
    chk("i1_addr",  imem_addr, 32'h8);

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0800_0010;
    step();
    imem_ack = 1'b0;
    chk("i2_pcout", pc_out, 32'h8);
    chk("i2_valid", {31'h0, out_valid}, 32'h1);

    // Jump from HOLD at pc_out=8: target {0, 26'h10, 00} = 0x40
    jump = 1'b1; jump_index = 26'h0000010;
    step();
    jump = 1'b0;
    chk("jmp_valid", {31'h0, out_valid}, 32'h0);
    chk("jmp_addr",  imem_addr, 32'h40);
    chk("jmp_req",   {31'h0, imem_req}, 32'h1);

    // Branch during waiting FETCH; ack 3 cycles later is squashed
    branch_taken = 1'b1; branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    chk("sq_addr_stable", imem_addr, 32'h40);
    step();
    step();
    chk("sq_addr_stable2", imem_addr, 32'h40);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("sq_valid", {31'h0, out_valid}, 32'h0);
    chk("sq_addr",  imem_addr, 32'h100);
    chk("sq_req",   {31'h0, imem_req}, 32'h1);
    chk("sq_instr", instr, 32'h0800_0010);

    imem_ack = 1'b1; imem_rdata = 32'h1000_0003;
    step();
    imem_ack = 1'b0;
    chk("i3_pcout", pc_out, 32'h100);
    chk("i3_opc",   {26'h0, opcode}, 32'h04);

    // Jump and branch together: pc_out+4=0x104 -> {0, 26'h20, 00} = 0x80
    jump = 1'b1; jump_index = 26'h0000020;
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    chk("both_addr",  imem_addr, 32'h80);
    chk("both_valid", {31'h0, out_valid}, 32'h0);

    // Branch in same cycle as ack: data dropped, low bits masked
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    branch_taken = 1'b1; branch_target = 32'h3FE;
    step();
    imem_ack = 1'b0; branch_taken = 1'b0;
    chk("same_valid", {31'h0, out_valid}, 32'h0);
    chk("same_addr",  imem_addr, 32'h3FC);
    chk("same_req",   {31'h0, imem_req}, 32'h1);

    // Reach 0xFFFFFFFC via a pending redirect, then wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    chk("pend_addr",  imem_addr, 32'hFFFF_FFFC);
    chk("pend_valid", {31'h0, out_valid}, 32'h0);
    imem_rdata = 32'h0000_0000;
    step();
    imem_ack = 1'b0;
    chk("wrap_pcout", pc_out, 32'hFFFF_FFFC);
    chk("wrap_addr",  imem_addr, 32'h0);

    // Later redirect overwrites pend_pc: pc_out+4 wraps to 0 -> 0xC0
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h500;
    step();
    branch_taken = 1'b0;
    jump = 1'b1; jump_index = 26'h0000030;
    step();
    jump = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    imem_ack = 1'b0;
    chk("ovr_addr",  imem_addr, 32'hC0);
    chk("ovr_valid", {31'h0, out_valid}, 32'h0);

    // Reset mid-FETCH, ack in the following IDLE cycle is ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_req",   {31'h0, imem_req}, 32'h0);
    chk("mrst_pcout", pc_out, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    imem_ack = 1'b0;
    chk("mrst_valid", {31'h0, out_valid}, 32'h0);
    chk("mrst_req2",  {31'h0, imem_req}, 32'h1);
    chk("mrst_addr",  imem_addr, 32'h0);
    chk("mrst_instr", instr, 32'h0);

    imem_ack = 1'b1; imem_rdata = 32'hAC22_0008;
    step();
    imem_ack = 1'b0;
    chk("post_valid", {31'h0, out_valid}, 32'h1);
    chk("post_pcout", pc_out, 32'h0);
    chk("post_opc",   {26'h0, opcode}, 32'h2B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_if_stage
`default_nettype wire
